// File: rtl/fb_loader_scanout_if.sv
// Bundle of ROM, RAM, VGA-timing and pixel signals around the frame-buffer controller.
// master = controller side, slave = memories / timing / RGB side.
interface fb_loader_scanout_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 19
);
   logic                  start_i_fb;
   logic                  rom_re_o;
   logic [ADDR_WIDTH-1:0] rom_addr_o;
   logic [DATA_WIDTH-1:0] rom_data_i;
   logic                  ram_we_o;
   logic                  ram_re_o;
   logic [ADDR_WIDTH-1:0] ram_addr_o;
   logic [DATA_WIDTH-1:0] ram_data_o;
   logic [DATA_WIDTH-1:0] ram_data_i;
   logic                  p_tick_i;
   logic                  video_on_i;
   logic                  frame_start_i;
   logic [DATA_WIDTH-1:0] pix_data_o;
   logic                  pix_valid_o;
   logic                  load_done_o;
   logic                  busy_o;
   logic [1:0]            state_o;

   modport master (
      input  start_i_fb, rom_data_i, ram_data_i, p_tick_i, video_on_i, frame_start_i,
      output rom_re_o, rom_addr_o, ram_we_o, ram_re_o, ram_addr_o, ram_data_o,
             pix_data_o, pix_valid_o, load_done_o, busy_o, state_o
   );

   modport slave (
      output start_i_fb, rom_data_i, ram_data_i, p_tick_i, video_on_i, frame_start_i,
      input  rom_re_o, rom_addr_o, ram_we_o, ram_re_o, ram_addr_o, ram_data_o,
             pix_data_o, pix_valid_o, load_done_o, busy_o, state_o
   );
endinterface

// File: rtl/fb_loader_scanout.sv
// Frame-buffer controller: copies ROM into frame RAM, then scans RAM out in raster order.
// Define FB_RELOAD_EN to allow start_i_fb in SCAN to trigger a reload at the next frame start.
module fb_loader_scanout #(
   parameter int DATA_WIDTH = 8,
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int RAM_DEPTH  = H_RES * V_RES,
   parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
   input  logic                 clk_i_fb,
   input  logic                 rstn_i_fb,
   fb_loader_scanout_if.master  fb
);
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SCAN = 2'd2} state_t;

   localparam logic [ADDR_WIDTH:0]   LOAD_LAST = (ADDR_WIDTH + 1)'(RAM_DEPTH);
   localparam logic [ADDR_WIDTH:0]   LOAD_ONE  = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] SCAN_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH:0]   load_cnt_reg, load_cnt_next;
   logic [ADDR_WIDTH-1:0] scan_cnt_reg, scan_cnt_next;
   logic                  pix_valid_reg, pix_valid_next;
   logic [ADDR_WIDTH-1:0] scan_addr;
   logic                  rd;
   logic                  reload_go;

`ifdef FB_RELOAD_EN
   logic reload_pending_reg;

   always_ff @(posedge clk_i_fb or negedge rstn_i_fb) begin
      if (!rstn_i_fb) begin
         reload_pending_reg <= 1'b0;
      end else if (state_reg == SCAN && fb.start_i_fb) begin
         reload_pending_reg <= 1'b1;
      end else if (state_reg == LOAD && state_next == SCAN) begin
         reload_pending_reg <= 1'b0;
      end
   end

   assign reload_go = (state_reg == SCAN) && fb.frame_start_i && reload_pending_reg;
`else
   assign reload_go = 1'b0;
`endif

   // A reload-triggering frame start suppresses the read so no pixel leaks into LOAD.
   assign rd        = fb.video_on_i & fb.p_tick_i & ~reload_go;
   assign scan_addr = fb.frame_start_i ? '0 : scan_cnt_reg;

   always_ff @(posedge clk_i_fb or negedge rstn_i_fb) begin
      if (!rstn_i_fb) begin
         state_reg     <= IDLE;
         load_cnt_reg  <= '0;
         scan_cnt_reg  <= '0;
         pix_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         load_cnt_reg  <= load_cnt_next;
         scan_cnt_reg  <= scan_cnt_next;
         pix_valid_reg <= pix_valid_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      load_cnt_next  = '0;
      scan_cnt_next  = scan_cnt_reg;
      pix_valid_next = 1'b0;
      fb.rom_re_o    = 1'b0;
      fb.rom_addr_o  = '0;
      fb.ram_we_o    = 1'b0;
      fb.ram_re_o    = 1'b0;
      fb.ram_addr_o  = '0;
      fb.ram_data_o  = '0;
      fb.load_done_o = 1'b0;

      case (state_reg)
         IDLE: begin
            scan_cnt_next = '0;
            if (fb.start_i_fb) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            scan_cnt_next = '0;
            load_cnt_next = load_cnt_reg + LOAD_ONE;
            if (load_cnt_reg != LOAD_LAST) begin
               fb.rom_re_o   = 1'b1;
               fb.rom_addr_o = load_cnt_reg[ADDR_WIDTH-1:0];
            end
            // Write lags the ROM read by one clock, when its data arrives.
            if (load_cnt_reg != '0) begin
               fb.ram_we_o   = 1'b1;
               fb.ram_addr_o = load_cnt_reg[ADDR_WIDTH-1:0] - ADDR_ONE;
               fb.ram_data_o = fb.rom_data_i;
            end
            if (load_cnt_reg == LOAD_LAST) begin
               fb.load_done_o = 1'b1;
               load_cnt_next  = '0;
               state_next     = SCAN;
            end
         end
         SCAN: begin
            if (reload_go) begin
               scan_cnt_next = '0;
               state_next    = LOAD;
            end else begin
               fb.ram_re_o    = rd;
               fb.ram_addr_o  = scan_addr;
               pix_valid_next = rd;
               if (rd) begin
                  scan_cnt_next = (scan_addr == SCAN_LAST) ? '0 : scan_addr + ADDR_ONE;
               end else if (fb.frame_start_i) begin
                  scan_cnt_next = '0;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign fb.pix_valid_o = pix_valid_reg;
   assign fb.pix_data_o  = pix_valid_reg ? fb.ram_data_i : '0;
   assign fb.busy_o      = (state_reg == LOAD);
   assign fb.state_o     = state_reg;
endmodule

// File: tb/tb_fb_loader_scanout.sv
// Directed bench for fb_loader_scanout with ROM/RAM models and a pixel scoreboard (ROM[a]=a).
`timescale 1ns/1ps
`define CHK(tag, obs, exp) chk_do(tag, 64'(obs), 64'(exp))
module tb_fb_loader_scanout;
   localparam int DW    = 8;
   localparam int HR    = 8;
   localparam int VR    = 4;
   localparam int DEPTH = HR * VR;
   localparam int AW    = 5;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic clk_i_fb  = 1'b0;
   logic rstn_i_fb = 1'b0;
   always #5 clk_i_fb = ~clk_i_fb;

   fb_loader_scanout_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   fb_loader_scanout #(.DATA_WIDTH(DW), .H_RES(HR), .V_RES(VR)) dut (
      .clk_i_fb  (clk_i_fb),
      .rstn_i_fb (rstn_i_fb),
      .fb        (bus)
   );

   logic [DW-1:0] ram_mem [DEPTH];
   always @(posedge clk_i_fb) begin
      if (bus.rom_re_o) bus.rom_data_i <= DW'(bus.rom_addr_o);
      if (bus.ram_we_o) ram_mem[bus.ram_addr_o] <= bus.ram_data_o;
      if (bus.ram_re_o) bus.ram_data_i <= ram_mem[bus.ram_addr_o];
   end

   int tests = 0;
   int fails = 0;
   logic [AW-1:0] exp_scan = '0;
   logic          rd_prev  = 1'b0;
   logic [DW-1:0] pix_q [$];
   logic [AW-1:0] rom_q [$];
   logic [AW-1:0] wr_q  [$];

   task automatic chk_do(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) begin
         $display("[TB] %s obs=%0h exp=%0h ok", tag, obs, exp);
      end else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i_fb);
      #1;
   endtask

   task automatic check_idle(input string tag);
      `CHK({tag, "_state"}, bus.state_o, 0);
      `CHK({tag, "_outs"}, {bus.rom_re_o, bus.rom_addr_o, bus.ram_we_o, bus.ram_re_o,
                            bus.ram_addr_o, bus.ram_data_o, bus.pix_data_o, bus.pix_valid_o,
                            bus.load_done_o, bus.busy_o}, 0);
   endtask

   task automatic scan_cycle(input logic vid, input logic pt, input logic fs);
      logic          rd;
      logic [AW-1:0] a;
      bus.video_on_i    = vid;
      bus.p_tick_i      = pt;
      bus.frame_start_i = fs;
      rd = vid & pt;
      a  = fs ? '0 : exp_scan;
      if (rd) pix_q.push_back(DW'(a));
      @(negedge clk_i_fb);
      `CHK("scan_state", bus.state_o, 2);
      `CHK("ram_re", bus.ram_re_o, rd);
      if (rd) `CHK("scan_addr", bus.ram_addr_o, a);
      `CHK("pix_valid", bus.pix_valid_o, rd_prev);
      if (rd_prev) begin
         if (pix_q.size() > 0) `CHK("pix_data", bus.pix_data_o, pix_q.pop_front());
         else `CHK("pix_queue_empty", 1, 0);
      end else begin
         `CHK("pix_zero", bus.pix_data_o, 0);
      end
      `CHK("we_re_excl", bus.ram_we_o & bus.ram_re_o, 0);
      if (rd) exp_scan = (a == LAST) ? '0 : a + AW'(1);
      else if (fs) exp_scan = '0;
      rd_prev = rd;
      tick();
   endtask

   initial begin
      int  done_cnt;
      int  done_at;
      bit  found;
      logic [AW-1:0] e;

      for (int i = 0; i < 4; i++) begin
         bus.start_i_fb    = 1'($urandom_range(0, 1));
         bus.video_on_i    = 1'($urandom_range(0, 1));
         bus.p_tick_i      = 1'($urandom_range(0, 1));
         bus.frame_start_i = 1'($urandom_range(0, 1));
         @(negedge clk_i_fb);
         check_idle("reset");
         tick();
      end
      bus.start_i_fb = 1'b0; bus.video_on_i = 1'b0; bus.p_tick_i = 1'b0; bus.frame_start_i = 1'b0;
      rstn_i_fb = 1'b1;
      tick();

      for (int a = 0; a < DEPTH; a++) begin
         rom_q.push_back(AW'(a));
         wr_q.push_back(AW'(a));
      end
      bus.start_i_fb = 1'b1;
      tick();
      bus.start_i_fb = 1'b0;
      done_cnt = 0;
      done_at  = -1;
      for (int c = 0; c <= DEPTH; c++) begin
         @(negedge clk_i_fb);
         `CHK("load_busy", bus.busy_o, 1);
         `CHK("load_pix_valid", bus.pix_valid_o, 0);
         tests++;
         if (bus.busy_o !== 1'b1) begin
            fails++;
            $error("FAIL load_busy_direct observed=%0b expected=1", bus.busy_o);
         end else begin
            $display("[TB] load_busy_direct cycle=%0d ok", c);
         end
         tests++;
         if ((bus.ram_we_o & bus.ram_re_o) !== 1'b0) begin
            fails++;
            $error("FAIL load_we_re_direct cycle=%0d", c);
         end else begin
            $display("[TB] load_we_re_direct cycle=%0d ok", c);
         end
         if (bus.rom_re_o) begin
            if (rom_q.size() > 0) `CHK("rom_addr", bus.rom_addr_o, rom_q.pop_front());
            else `CHK("rom_extra_read", 1, 0);
         end
         if (bus.ram_we_o) begin
            if (wr_q.size() > 0) begin
               e = wr_q.pop_front();
               `CHK("wr_addr", bus.ram_addr_o, e);
               `CHK("wr_data", bus.ram_data_o, e);
            end else begin
               `CHK("extra_write", 1, 0);
            end
         end
         `CHK("we_re_excl", bus.ram_we_o & bus.ram_re_o, 0);
         if (bus.load_done_o) begin
            done_cnt++;
            done_at = c;
         end
         tick();
      end
      `CHK("rom_reads_left", rom_q.size(), 0);
      `CHK("writes_left", wr_q.size(), 0);
      `CHK("load_done_count", done_cnt, 1);
      `CHK("load_done_cycle", done_at, DEPTH);
      tests++;
      if (done_cnt !== 1) begin
         fails++;
         $error("FAIL load_done_count_direct observed=%0d expected=1", done_cnt);
      end else begin
         $display("[TB] load_done_count_direct ok");
      end
      @(negedge clk_i_fb);
      `CHK("post_load_state", bus.state_o, 2);
      tick();

      scan_cycle(1'b0, 1'b0, 1'b1);
      for (int i = 0; i <= DEPTH; i++) scan_cycle(1'b1, 1'b1, 1'b0);
      scan_cycle(1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 10; i++) begin
         bus.video_on_i    = 1'b0;
         bus.p_tick_i      = 1'b1;
         bus.frame_start_i = 1'b0;
         @(negedge clk_i_fb);
         tests++;
         if (bus.ram_re_o !== 1'b0 || bus.pix_valid_o !== 1'b0) begin
            fails++;
            $error("FAIL gate_direct re=%0b valid=%0b", bus.ram_re_o, bus.pix_valid_o);
         end else begin
            $display("[TB] gate_direct cycle=%0d ok", i);
         end
         #1;
         scan_cycle(1'b0, 1'b1, 1'b0);
      end
      scan_cycle(1'b1, 1'b1, 1'b0);
      scan_cycle(1'b1, 1'b0, 1'b0);
      scan_cycle(1'b1, 1'b0, 1'b0);
      scan_cycle(1'b1, 1'b1, 1'b1);
      scan_cycle(1'b1, 1'b1, 1'b0);
      scan_cycle(1'b0, 1'b0, 1'b0);

      bus.start_i_fb = 1'b1;
      scan_cycle(1'b0, 1'b0, 1'b0);
      bus.start_i_fb = 1'b0;
      scan_cycle(1'b0, 1'b0, 1'b0);
      scan_cycle(1'b0, 1'b0, 1'b0);
`ifdef FB_RELOAD_EN
      bus.frame_start_i = 1'b1;
      bus.video_on_i    = 1'b1;
      bus.p_tick_i      = 1'b1;
      @(negedge clk_i_fb);
      `CHK("reload_trigger_no_read", bus.ram_re_o, 0);
      tick();
      bus.frame_start_i = 1'b0;
      bus.video_on_i    = 1'b0;
      bus.p_tick_i      = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 2 * DEPTH; c++) begin
         @(negedge clk_i_fb);
         if (c == 0) `CHK("reload_state_load", bus.state_o, 1);
         `CHK("reload_pix_valid", bus.pix_valid_o, 0);
         if (bus.load_done_o) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      `CHK("reload_done_seen", found, 1);
      tick();
      @(negedge clk_i_fb);
      `CHK("reload_back_scan", bus.state_o, 2);
      tick();
      rd_prev = 1'b0;
      pix_q.delete();
      scan_cycle(1'b0, 1'b0, 1'b1);
      scan_cycle(1'b1, 1'b1, 1'b0);
      scan_cycle(1'b1, 1'b1, 1'b0);
      scan_cycle(1'b0, 1'b0, 1'b0);
`else
      scan_cycle(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) scan_cycle(1'b0, 1'b0, 1'b0);
      @(negedge clk_i_fb);
      `CHK("no_reload_busy", bus.busy_o, 0);
      tick();
`endif

      rstn_i_fb = 1'b0;
      tick();
      rstn_i_fb = 1'b1;
      tick();
      bus.start_i_fb = 1'b1;
      tick();
      bus.start_i_fb = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 2 * DEPTH; c++) begin
         @(negedge clk_i_fb);
         if (bus.rom_re_o && bus.rom_addr_o == AW'(10)) begin
            rstn_i_fb = 1'b0;
            #1;
            check_idle("midload_reset");
            found = 1'b1;
            break;
         end
         tick();
      end
      `CHK("midload_addr10_seen", found, 1);
      tests++;
      if (bus.state_o !== 2'd0) begin
         fails++;
         $error("FAIL midload_state_direct observed=%0d expected=0", bus.state_o);
      end else begin
         $display("[TB] midload_state_direct ok");
      end
      tick();
      rstn_i_fb = 1'b1;
      tick();
      bus.start_i_fb = 1'b1;
      tick();
      bus.start_i_fb = 1'b0;
      @(negedge clk_i_fb);
      `CHK("restart_state", bus.state_o, 1);
      `CHK("restart_rom0", {bus.rom_re_o, bus.rom_addr_o}, {1'b1, 5'd0});
      `CHK("restart_no_we", bus.ram_we_o, 0);
      tick();
      @(negedge clk_i_fb);
      `CHK("restart_rom1", bus.rom_addr_o, 1);
      `CHK("restart_wr0", {bus.ram_we_o, bus.ram_addr_o, bus.ram_data_o}, {1'b1, 5'd0, 8'd0});
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
